// File: rtl/fxp_scaler_pkg.sv
// Shared width arithmetic and reduction-mode selection for the fixed-point
// scaler datapath p = (a + d) * b + c.
// Optional feature macro: FIXEDPOINTSCALER_SAT_EN (see fxp_sat_trunc).
package fxp_scaler_pkg;

  // How the full-precision sum is mapped onto the output width.
  typedef enum logic [1:0] {
    RED_EXTEND = 2'd0,  // output wider than sum: sign-extend
    RED_PASS   = 2'd1,  // same width: straight copy
    RED_NARROW = 2'd2   // output narrower: wrap or saturate
  } red_mode_e;

  // Default operand and result widths.
  localparam int BA_DEF = 27;
  localparam int BB_DEF = 16;
  localparam int BC_DEF = 27;
  localparam int BD_DEF = 27;
  localparam int BP_DEF = 45;

  function automatic int max_i(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Width of the pre-adder result (one growth bit over the wider operand).
  function automatic int aw(input int ba, input int bd);
    return max_i(ba, bd) + 1;
  endfunction

  // Width of the product: signed pre-add times zero-extended unsigned b.
  function automatic int mw(input int ba, input int bb, input int bd);
    return max_i(ba, bd) + bb + 2;
  endfunction

  // Full-precision width of the post-adder sum.
  function automatic int fw(input int ba, input int bb, input int bc, input int bd);
    return max_i(mw(ba, bb, bd), bc) + 1;
  endfunction

  function automatic red_mode_e red_mode(input int full_w, input int out_w);
    if (out_w > full_w)
      return RED_EXTEND;
    else if (out_w == full_w)
      return RED_PASS;
    else
      return RED_NARROW;
  endfunction

  // Number of upper sum bits that must agree for a value to fit in out_w bits
  // (the output sign bit plus every bit above it).
  function automatic int sat_guard_bits(input int full_w, input int out_w);
    return full_w - out_w + 1;
  endfunction

endpackage

// File: rtl/fxp_sat_trunc.sv
// Combinational width reduction of the full-precision sum s (FW bits) onto the
// BP-bit result. When BP < FW the default build wraps (keeps the low BP bits);
// with FIXEDPOINTSCALER_SAT_EN defined it clamps to the signed BP range.
module fxp_sat_trunc
  import fxp_scaler_pkg::*;
#(
  parameter int FW = 46,
  parameter int BP = 45
) (
  input  logic signed [FW-1:0] s,
  output logic signed [BP-1:0] y
);

  localparam red_mode_e MODE = red_mode(FW, BP);

  if (MODE == RED_EXTEND) begin : g_extend
    assign y = {{(BP-FW){s[FW-1]}}, s};
  end else if (MODE == RED_PASS) begin : g_pass
    assign y = s;
  end else begin : g_narrow
    localparam int GB = sat_guard_bits(FW, BP);
    localparam logic signed [BP-1:0] SAT_MAX = {1'b0, {(BP-1){1'b1}}};
    localparam logic signed [BP-1:0] SAT_MIN = {1'b1, {(BP-1){1'b0}}};

    // Output sign bit and everything above it; they all agree iff s fits.
    logic [GB-1:0] guard;
    assign guard = s[FW-1:BP-1];

`ifdef FIXEDPOINTSCALER_SAT_EN
    // Clamp out-of-range sums to the nearest representable extreme.
    always_comb begin
      y = s[BP-1:0];
      if ((guard != '0) && (guard != '1))
        y = s[FW-1] ? SAT_MIN : SAT_MAX;
    end
`else
    // Two's-complement wrap: the guard bits are intentionally dropped.
    logic unused_guard;
    logic unused_limits;
    assign unused_guard  = ^guard;
    assign unused_limits = ^{SAT_MAX, SAT_MIN};
    assign y = s[BP-1:0];
`endif
  end

endmodule

// File: rtl/fixed_point_scaler.sv
// Four-stage pipelined scaler p = (a + d) * b + c (pre-add, multiply,
// post-add), one operand set per clock, no handshake. a, c, d are signed,
// b is an unsigned scale factor. Result appears on p after the third edge
// following the capture edge. clr synchronously zeroes every stage.
// Optional feature macro: FIXEDPOINTSCALER_SAT_EN (saturate instead of wrap
// when BP is narrower than the full-precision sum).
module fixed_point_scaler
  import fxp_scaler_pkg::*;
#(
  parameter int BA = BA_DEF,
  parameter int BB = BB_DEF,
  parameter int BC = BC_DEF,
  parameter int BD = BD_DEF,
  parameter int BP = BP_DEF
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic signed [BA-1:0] a,
  input  logic        [BB-1:0] b,
  input  logic signed [BC-1:0] c,
  input  logic signed [BD-1:0] d,
  output logic signed [BP-1:0] p
);

  localparam int AW = aw(BA, BD);
  localparam int MW = mw(BA, BB, BD);
  localparam int FW = fw(BA, BB, BC, BD);

  // S1: captured operands.
  logic signed [BA-1:0] a_q;
  logic        [BB-1:0] b_q;
  logic signed [BC-1:0] c1_q;
  logic signed [BD-1:0] d_q;

  // S2: pre-adder result, offset and scale delayed.
  logic signed [AW-1:0] ad_q;
  logic        [BB-1:0] b2_q;
  logic signed [BC-1:0] c2_q;

  // S3: product, offset delayed.
  logic signed [MW-1:0] m_q;
  logic signed [BC-1:0] c3_q;

  // Combinational values feeding each register stage.
  logic signed [AW-1:0] ad_n;
  logic signed [MW-1:0] ad_ext;
  logic signed [MW-1:0] b_ext;
  logic signed [MW-1:0] m_n;
  logic signed [FW-1:0] s_n;
  logic signed [BP-1:0] p_n;

  // Pre-add, multiply and post-add arithmetic between the register stages.
  always_comb begin
    ad_n   = {{(AW-BA){a_q[BA-1]}}, a_q} + {{(AW-BD){d_q[BD-1]}}, d_q};
    ad_ext = {{(MW-AW){ad_q[AW-1]}}, ad_q};
    // b is a magnitude: a zero top bit keeps 16'hFFFF at 65535 in the signed product.
    b_ext  = {{(MW-BB){1'b0}}, b2_q};
    m_n    = ad_ext * b_ext;
    s_n    = {{(FW-MW){m_q[MW-1]}}, m_q} + {{(FW-BC){c3_q[BC-1]}}, c3_q};
  end

  fxp_sat_trunc #(
    .FW (FW),
    .BP (BP)
  ) u_reduce (
    .s (s_n),
    .y (p_n)
  );

  // S1: register the raw operands; clr overrides the data path.
  // NOTE: every pipeline register is cleared so no unknown value can ever reach p.
  always_ff @(posedge clk) begin
    if (clr) begin
      a_q  <= '0;
      b_q  <= '0;
      c1_q <= '0;
      d_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
      a_q  <= a;
      b_q  <= b;
      c1_q <= c;
      d_q  <= d;
    end
  end

  // S2: register the pre-add sum and carry b and c forward.
  always_ff @(posedge clk) begin
    if (clr) begin
      ad_q <= '0;
      b2_q <= '0;
      c2_q <= '0;
    end else begin
      ad_q <= ad_n;
      b2_q <= b_q;
      c2_q <= c1_q;
    end
  end

  // S3: register the product and carry c forward.
  always_ff @(posedge clk) begin
    if (clr) begin
      m_q  <= '0;
      c3_q <= '0;
    end else begin
      m_q  <= m_n;
      c3_q <= c2_q;
    end
  end

  // S4: register the reduced post-add result.
  always_ff @(posedge clk) begin
    if (clr)
      p <= '0;
    else
      p <= p_n;
  end

endmodule

// File: tb/tb_fixed_point_scaler.sv
// Directed bench for fixed_point_scaler: reset behaviour, exact latency,
// a streamed table of vectors, clr mid-stream and a narrow-output instance
// whose expectations follow FIXEDPOINTSCALER_SAT_EN.
module tb_fixed_point_scaler;

  logic                 clk = 1'b0;
  logic                 clr;
  logic signed [26:0]   a;
  logic        [15:0]   b;
  logic signed [26:0]   c;
  logic signed [26:0]   d;
  logic signed [44:0]   p;
  logic signed [15:0]   p16;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic signed [26:0] a;
    logic        [15:0] b;
    logic signed [26:0] c;
    logic signed [26:0] d;
    logic signed [44:0] p;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  fixed_point_scaler dut (
    .clk (clk),
    .clr (clr),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .p   (p)
  );

  fixed_point_scaler #(.BP(16)) dut16 (
    .clk (clk),
    .clr (clr),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .p   (p16)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic signed [26:0] ia, input logic [15:0] ib,
                       input logic signed [26:0] ic, input logic signed [26:0] id);
    a = ia;
    b = ib;
    c = ic;
    d = id;
  endtask

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    logic signed [63:0] exp_v;

    // Table: three corner vectors followed by the (i, 2i, 3, i) stream.
    vecs[0] = '{a: 27'sd3, b: 16'd5, c: -27'sd7, d: 27'sd4, p: 45'sd28};
    vecs[1] = '{a: 27'(-67108864), b: 16'hFFFF, c: 27'(-67108864),
                d: 27'(-67108864), p: 45'(-64'sd8796025913344)};
    vecs[2] = '{a: -27'sd5, b: 16'd10, c: 27'sd100, d: 27'sd2, p: 45'sd70};
    for (int i = 0; i < 16; i++)
      vecs[3 + i] = '{a: 27'(i), b: 16'd3, c: 27'(i), d: 27'(2 * i), p: 45'(10 * i)};

    // Reset held for 10 cycles with arbitrary operands.
    clr = 1'b1;
    for (int t = 0; t < 10; t++) begin
      drive(27'($urandom), 16'($urandom), 27'($urandom), 27'($urandom));
      tick();
      check($sformatf("clr_hold_%0d", t), p, 0);
    end
    check("clr_hold_p16", p16, 0);

    // Release with zero operands: output stays zero.
    clr = 1'b0;
    drive('0, '0, '0, '0);
    for (int t = 0; t < 5; t++) begin
      tick();
      check($sformatf("zero_after_clr_%0d", t), p, 0);
    end

    // Exact latency: result after the 4th edge, zeros before and after.
    drive(27'sd3, 16'd5, -27'sd7, 27'sd4);
    tick();
    check("lat_edge1", p, 0);
    drive('0, '0, '0, '0);
    tick();
    check("lat_edge2", p, 0);
    tick();
    check("lat_edge3", p, 0);
    tick();
    check("lat_edge4", p, 28);
    tick();
    check("lat_edge5", p, 0);

    // Streamed table, one vector per cycle, no bubbles.
    for (int t = 0; t < NV + 3; t++) begin
      if (t < NV)
        drive(vecs[t].a, vecs[t].b, vecs[t].c, vecs[t].d);
      else
        drive('0, '0, '0, '0);
      tick();
      if (t >= 3)
        check($sformatf("stream_vec%0d", t - 3), p, vecs[t - 3].p);
    end

    // Flush, then clr for one cycle mid-stream (asserted for the 6th edge).
    drive('0, '0, '0, '0);
    for (int t = 0; t < 4; t++) tick();
    for (int t = 0; t < 12; t++) begin
      drive(27'(t + 1), 16'd3, 27'(t + 1), 27'(2 * (t + 1)));
      clr = (t == 5);
      tick();
      if (t >= 3 && !(t >= 5 && t <= 8))
        exp_v = 64'(10 * (t - 2));
      else
        exp_v = 0;
      check($sformatf("clr_mid_%0d", t), p, exp_v);
    end
    clr = 1'b0;

    // Narrow output instance: s = 200000, then s = -200000.
    drive(27'sd1000, 16'd100, 27'sd0, 27'sd1000);
    for (int t = 0; t < 4; t++) tick();
    check("wide_pos", p, 200000);
`ifdef FIXEDPOINTSCALER_SAT_EN
    check("bp16_pos_sat", p16, 32767);
`else
    check("bp16_pos_wrap", p16, 3392);
`endif
    drive(27'sd1000, 16'd100, -27'sd400000, 27'sd1000);
    for (int t = 0; t < 4; t++) tick();
    check("wide_neg", p, -200000);
`ifdef FIXEDPOINTSCALER_SAT_EN
    check("bp16_neg_sat", p16, -32768);
`else
    check("bp16_neg_wrap", p16, -3392);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
